adder_share_arbiter: RTL

//   Shares one WIDTH-bit adder (sum = a + b, WIDTH+1 bits) among NUM_REQ requesters.

---
 rtl/adder_share_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NUM_REQ requesters.
// One operation in flight: IDLE accepts, EXEC adds, RESP holds the tagged result.
module adder_share_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 4,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH:0]           rsp_sum,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_sum;
    logic             r_valid;

    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_scan;
    logic             w_found;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_accept;
    logic             w_rsp_hs;
    int               w_idx;

    // Scan from the pointer downwards so the closest valid requester wins last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        w_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_scan = IDW'(w_idx);
            if (req_valid[w_scan]) begin
                w_found = 1'b1;
                w_win   = w_scan;
            end
        end
    end

    always_comb begin
        w_a       = '0;
        w_b       = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
                req_ready[i] = rst_n && (r_state == S_IDLE) && w_found;
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found;
    assign w_rsp_hs = (r_state == S_RESP) && rsp_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= w_a;
                r_b  <= w_b;
                r_id <= w_win;
            end
            if (r_state == S_EXEC) begin
                r_sum   <= {1'b0, r_a} + {1'b0, r_b};
                r_valid <= 1'b1;
            end
            if (w_rsp_hs) begin
                r_valid <= 1'b0;
                if (r_id == IDW'(NUM_REQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= r_id + 1'b1;
                end
            end
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;
    assign busy      = (r_state != S_IDLE);

endmodule
